// File: rtl/plic_axil_pkg.sv
// Shared constants, types and lane-index helper for the PLIC AXI4-Lite bridge.
// No logic of its own; imported by the bridge and its holding buffers.
package plic_axil_pkg;

   localparam logic [1:0]  RESP_OKAY              = 2'b00;
   localparam logic [1:0]  RESP_SLVERR            = 2'b10;
   localparam logic [21:0] DEFAULT_REG_ADDR_LIMIT = 22'h20_1000;

   typedef logic [31:0] reg_word_t;

   // A 64-bit bus carries two 32-bit register words; a 32-bit bus has one lane.
   function automatic int lane_idx(input int data_w, input logic addr_b2);
      return (data_w == 64) ? int'(addr_b2) : 0;
   endfunction

endpackage

// File: rtl/plic_axil_buf.sv
// One-entry valid/ready holding register; data held from accept until clr.
// Latency 1 (full rises at the accept edge); in_rdy drops while the entry is occupied.
module plic_axil_buf
   import plic_axil_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         full,
   output logic [W-1:0] out_dat,
   input  logic         clr
);

   assign in_rdy = en && !full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full    <= 1'b0;
         out_dat <= '0;
      end else if (clr) begin
         full    <= 1'b0;
      end else if (in_vld && in_rdy) begin
         full    <= 1'b1;
         out_dat <= in_dat;
      end
   end

endmodule

// File: rtl/plic_axil_bridge.sv
// AXI4-Lite slave front-end to the PLIC register port; optional PLIC_AXIL_SLVERR_EN for SLVERR on out-of-range.
// Write strobe 1 cycle after AW+W held, read data 1 cycle after AR; one B and one R outstanding, READY drops while held.
module plic_axil_bridge
   import plic_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 64,
   parameter int C_S_AXI_ADDR_WIDTH = 22,
   parameter logic [C_S_AXI_ADDR_WIDTH-1:0] REG_ADDR_LIMIT =
      C_S_AXI_ADDR_WIDTH'(DEFAULT_REG_ADDR_LIMIT)
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]   reg_waddr,
   output logic [31:0]                     reg_wdata,
   output logic [3:0]                      reg_wstrb,
   output logic                            reg_wen,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]   reg_raddr,
   output logic                            reg_ren,
   input  logic [31:0]                     reg_rdata
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int SW = DW / 8;

   logic          ready_en;
   logic          aw_full;
   logic [AW-1:0] aw_q;
   logic          w_full;
   logic [SW+DW-1:0] w_q;
   logic          commit;
   logic          aw_in;
   int            wl;
   reg_word_t     wsel;
   logic [3:0]    ssel;
   logic          ar_hs;
   logic          ar_in;
   int            rl;
   logic [DW-1:0] rd_next;

   // READY stays low through reset and rises one edge after release.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) ready_en <= 1'b0;
      else                ready_en <= 1'b1;
   end

   plic_axil_buf #(.W(AW)) u_aw_buf (
      .clk     (S_AXI_ACLK),
      .rst_n   (S_AXI_ARESETN),
      .en      (ready_en),
      .in_vld  (S_AXI_AWVALID),
      .in_rdy  (S_AXI_AWREADY),
      .in_dat  (S_AXI_AWADDR),
      .full    (aw_full),
      .out_dat (aw_q),
      .clr     (commit)
   );

   plic_axil_buf #(.W(SW + DW)) u_w_buf (
      .clk     (S_AXI_ACLK),
      .rst_n   (S_AXI_ARESETN),
      .en      (ready_en),
      .in_vld  (S_AXI_WVALID),
      .in_rdy  (S_AXI_WREADY),
      .in_dat  ({S_AXI_WSTRB, S_AXI_WDATA}),
      .full    (w_full),
      .out_dat (w_q),
      .clr     (commit)
   );

   // Write path: commit waits for a free B slot so each write is strobed exactly once.
   assign commit = aw_full && w_full && !S_AXI_BVALID;
   assign aw_in  = aw_q < REG_ADDR_LIMIT;
   assign wl     = lane_idx(DW, aw_q[2]);

   always_comb begin
      wsel = w_q[wl*32 +: 32];
      ssel = w_q[DW + wl*4 +: 4];
   end

   assign reg_wen   = commit && aw_in;
   assign reg_waddr = {aw_q[AW-1:2], 2'b00};
   assign reg_wdata = wsel;
   assign reg_wstrb = ssel;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= RESP_OKAY;
      end else if (commit) begin
         S_AXI_BVALID <= 1'b1;
`ifdef PLIC_AXIL_SLVERR_EN
         S_AXI_BRESP  <= aw_in ? RESP_OKAY : RESP_SLVERR;
`else
         S_AXI_BRESP  <= RESP_OKAY;
`endif
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
         S_AXI_BVALID <= 1'b0;
      end
   end

   // Read path: ARREADY is blocked while R is held, so claim reads strobe once.
   assign S_AXI_ARREADY = ready_en && !S_AXI_RVALID;
   assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
   assign ar_in         = S_AXI_ARADDR < REG_ADDR_LIMIT;
   assign rl            = lane_idx(DW, S_AXI_ARADDR[2]);
   assign reg_ren       = ar_hs && ar_in;
   assign reg_raddr     = {S_AXI_ARADDR[AW-1:2], 2'b00};

   always_comb begin
      rd_next = '0;
      if (ar_in) rd_next[rl*32 +: 32] = reg_rdata;
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
         S_AXI_RRESP  <= RESP_OKAY;
      end else if (ar_hs) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= rd_next;
`ifdef PLIC_AXIL_SLVERR_EN
         S_AXI_RRESP  <= ar_in ? RESP_OKAY : RESP_SLVERR;
`else
         S_AXI_RRESP  <= RESP_OKAY;
`endif
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
         S_AXI_RVALID <= 1'b0;
      end
   end

   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_q[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_plic_axil_bridge.sv
// Directed, table-driven bench for plic_axil_bridge with a small register-file core model.
module tb_plic_axil_bridge;

   logic        clk;
   logic        rst_n;
   logic [21:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [21:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [21:0] reg_waddr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_wstrb;
   logic        reg_wen;
   logic [21:0] reg_raddr;
   logic        reg_ren;
   logic [31:0] reg_rdata;

`ifdef PLIC_AXIL_SLVERR_EN
   localparam logic [1:0] OOR_RESP = 2'b10;
`else
   localparam logic [1:0] OOR_RESP = 2'b00;
`endif

   plic_axil_bridge dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (3'b000),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (3'b000),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .reg_waddr     (reg_waddr),
      .reg_wdata     (reg_wdata),
      .reg_wstrb     (reg_wstrb),
      .reg_wen       (reg_wen),
      .reg_raddr     (reg_raddr),
      .reg_ren       (reg_ren),
      .reg_rdata     (reg_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: 16 words plus a fixed claim register at 0x20_0004.
   logic [31:0] mem [16];
   assign reg_rdata = (reg_raddr == 22'h20_0004) ? 32'd5 : mem[reg_raddr[5:2]];

   int n_checks = 0;
   int n_fail   = 0;
   int wen_cnt  = 0;
   int ren_cnt  = 0;
   int both_cnt = 0;
   int b_cnt    = 0;
   int r_cnt    = 0;
   logic [21:0] lw_addr;
   logic [31:0] lw_data;
   logic [3:0]  lw_strb;
   logic [1:0]  last_bresp;
   logic [63:0] last_rdata;
   logic [1:0]  last_rresp;

   typedef struct {
      logic [21:0] addr;
      logic [63:0] wd;
      logic [7:0]  ws;
      logic        wen;
      logic [21:0] waddr;
      logic [31:0] wdat;
      logic [3:0]  wstb;
   } wvec_t;

   typedef struct {
      logic [21:0] addr;
      logic        ren;
      logic [63:0] rdat;
   } rvec_t;

   wvec_t wv [7];
   rvec_t rv [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock: sample mid-low-phase, pass the rising edge, then retire handshakes.
   task automatic tick();
      logic aw_hs, w_hs, ar_hs, pend;
      #1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      ar_hs = arvalid && arready;
      pend  = reg_wen;
      if (reg_wen) begin
         wen_cnt++;
         lw_addr = reg_waddr;
         lw_data = reg_wdata;
         lw_strb = reg_wstrb;
      end
      if (reg_ren) ren_cnt++;
      if (reg_wen && reg_ren) both_cnt++;
      if (bvalid && bready) begin
         b_cnt++;
         last_bresp = bresp;
      end
      if (rvalid && rready) begin
         r_cnt++;
         last_rdata = rdata;
         last_rresp = rresp;
      end
      @(negedge clk);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      if (ar_hs) arvalid = 1'b0;
      if (pend)
         for (int b = 0; b < 4; b++)
            if (lw_strb[b]) mem[lw_addr[5:2]][8*b +: 8] = lw_data[8*b +: 8];
   endtask

   task automatic wait_b(input int target);
      int n = 0;
      while (b_cnt < target && n < 20) begin
         tick();
         n++;
      end
      chk("b_timeout", 64'(b_cnt >= target), 64'd1);
   endtask

   task automatic wait_r(input int target);
      int n = 0;
      while (r_cnt < target && n < 20) begin
         tick();
         n++;
      end
      chk("r_timeout", 64'(r_cnt >= target), 64'd1);
   endtask

   task automatic do_write(input logic [21:0] a, input logic [63:0] d, input logic [7:0] s);
      awaddr = a; awvalid = 1'b1;
      wdata = d; wstrb = s; wvalid = 1'b1;
      bready = 1'b1;
      wait_b(b_cnt + 1);
   endtask

   task automatic do_read(input logic [21:0] a);
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      wait_r(r_cnt + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, r0, b0, rc0, s0;
      logic [1:0] er;

      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      rst_n = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;

      wv[0] = '{22'h00_0008, 64'h1111_1111_2222_2222, 8'h0F, 1'b1, 22'h00_0008, 32'h2222_2222, 4'hF};
      wv[1] = '{22'h00_000C, 64'hAAAA_1234_BBBB_0000, 8'h30, 1'b1, 22'h00_000C, 32'hAAAA_1234, 4'h3};
      wv[2] = '{22'h00_0011, 64'hFFFF_FFFF_DEAD_BEEF, 8'hFF, 1'b1, 22'h00_0010, 32'hDEAD_BEEF, 4'hF};
      wv[3] = '{22'h00_0014, 64'h5555_5555_6666_6666, 8'h0F, 1'b1, 22'h00_0014, 32'h5555_5555, 4'h0};
      wv[4] = '{22'h30_0000, 64'h7777_7777_7777_7777, 8'hFF, 1'b0, 22'h0,       32'h0,         4'h0};
      wv[5] = '{22'h20_0FFC, 64'h0BAD_F00D_0000_0000, 8'hF0, 1'b1, 22'h20_0FFC, 32'h0BAD_F00D, 4'hF};
      wv[6] = '{22'h20_1000, 64'h8888_8888_8888_8888, 8'hFF, 1'b0, 22'h0,       32'h0,         4'h0};

      rv[0] = '{22'h00_0008, 1'b1, 64'h0000_0000_2222_2222};
      rv[1] = '{22'h00_000C, 1'b1, 64'h0000_1234_0000_0000};
      rv[2] = '{22'h00_0014, 1'b1, 64'h0000_0000_0000_0000};
      rv[3] = '{22'h20_0FFC, 1'b1, 64'h0BAD_F00D_0000_0000};
      rv[4] = '{22'h30_0000, 1'b0, 64'h0000_0000_0000_0000};
      rv[5] = '{22'h20_1000, 1'b0, 64'h0000_0000_0000_0000};
      rv[6] = '{22'h00_0010, 1'b1, 64'h0000_0000_DEAD_BEEF};

      // Reset state and READY rising one cycle after release
      repeat (3) @(negedge clk);
      #1;
      chk("rst_awready", 64'(awready), 64'd0);
      chk("rst_wready",  64'(wready),  64'd0);
      chk("rst_arready", 64'(arready), 64'd0);
      chk("rst_bvalid",  64'(bvalid),  64'd0);
      chk("rst_rvalid",  64'(rvalid),  64'd0);
      chk("rst_bresp",   64'(bresp),   64'd0);
      chk("rst_rresp",   64'(rresp),   64'd0);
      chk("rst_rdata",   rdata,        64'd0);
      chk("rst_wen_ren", 64'({reg_wen, reg_ren}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("idle_ready", 64'({awready, wready, arready}), 64'h7);
         chk("idle_valid", 64'({bvalid, rvalid}), 64'h0);
         tick();
      end

      // Table: writes
      for (int i = 0; i < 7; i++) begin
         w0 = wen_cnt;
         do_write(wv[i].addr, wv[i].wd, wv[i].ws);
         er = wv[i].wen ? 2'b00 : OOR_RESP;
         chk($sformatf("wr%0d_wen", i), 64'(wen_cnt - w0), 64'(wv[i].wen));
         chk($sformatf("wr%0d_bresp", i), 64'(last_bresp), 64'(er));
         if (wv[i].wen) begin
            chk($sformatf("wr%0d_waddr", i), 64'(lw_addr), 64'(wv[i].waddr));
            chk($sformatf("wr%0d_wdata", i), 64'(lw_data), 64'(wv[i].wdat));
            chk($sformatf("wr%0d_wstrb", i), 64'(lw_strb), 64'(wv[i].wstb));
         end
      end

      // Table: reads
      for (int i = 0; i < 7; i++) begin
         r0 = ren_cnt;
         do_read(rv[i].addr);
         er = rv[i].ren ? 2'b00 : OOR_RESP;
         chk($sformatf("rd%0d_ren", i), 64'(ren_cnt - r0), 64'(rv[i].ren));
         chk($sformatf("rd%0d_rdata", i), last_rdata, rv[i].rdat);
         chk($sformatf("rd%0d_rresp", i), 64'(last_rresp), 64'(er));
      end

      // W three cycles ahead of AW
      w0 = wen_cnt; b0 = b_cnt;
      wdata = 64'h0000_0007_0000_0000; wstrb = 8'hF0; wvalid = 1'b1; bready = 1'b1;
      repeat (3) tick();
      #1;
      chk("wfirst_no_wen", 64'(wen_cnt - w0), 64'd0);
      chk("wfirst_no_b", 64'(bvalid), 64'd0);
      awaddr = 22'h00_0004; awvalid = 1'b1;
      wait_b(b0 + 1);
      chk("wfirst_wen", 64'(wen_cnt - w0), 64'd1);
      chk("wfirst_waddr", 64'(lw_addr), 64'h4);
      chk("wfirst_wdata", 64'(lw_data), 64'h7);
      chk("wfirst_wstrb", 64'(lw_strb), 64'hF);
      chk("wfirst_bresp", 64'(last_bresp), 64'd0);

      // Claim read stalled by RREADY, with a second AR waiting behind it
      r0 = ren_cnt; rc0 = r_cnt;
      araddr = 22'h20_0004; arvalid = 1'b1; rready = 1'b0;
      tick();
      arvalid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("claim_rvalid", 64'(rvalid), 64'd1);
         chk("claim_rdata", rdata, 64'h0000_0005_0000_0000);
         chk("claim_arready", 64'(arready), 64'd0);
         chk("claim_once", 64'(ren_cnt - r0), 64'd1);
         tick();
      end
      rready = 1'b1;
      tick();
      #1;
      chk("claim_arready_back", 64'(arready), 64'd1);
      chk("claim_rvalid_drop", 64'(rvalid), 64'd0);
      wait_r(rc0 + 2);
      chk("claim_two_ren", 64'(ren_cnt - r0), 64'd2);
      chk("claim_rdata2", last_rdata, 64'h0000_0005_0000_0000);

      // Back-to-back writes with BREADY held low
      w0 = wen_cnt; b0 = b_cnt;
      awaddr = 22'h00_0018; awvalid = 1'b1; wdata = 64'h11; wstrb = 8'h0F; wvalid = 1'b1;
      bready = 1'b0;
      tick();
      awaddr = 22'h00_001C; awvalid = 1'b1; wdata = 64'h0000_0022_0000_0000; wstrb = 8'hF0; wvalid = 1'b1;
      repeat (6) tick();
      #1;
      chk("b2b_one_wen", 64'(wen_cnt - w0), 64'd1);
      chk("b2b_first_addr", 64'(lw_addr), 64'h18);
      chk("b2b_bvalid", 64'(bvalid), 64'd1);
      chk("b2b_bufs_full", 64'({awready, wready}), 64'd0);
      bready = 1'b1;
      wait_b(b0 + 2);
      chk("b2b_two_wen", 64'(wen_cnt - w0), 64'd2);
      chk("b2b_addr2", 64'(lw_addr), 64'h1C);
      chk("b2b_data2", 64'(lw_data), 64'h22);
      chk("b2b_strb2", 64'(lw_strb), 64'hF);

      // Read and write of the same register in one cycle
      s0 = both_cnt; rc0 = r_cnt; b0 = b_cnt;
      awaddr = 22'h00_0018; awvalid = 1'b1; wdata = 64'h99; wstrb = 8'h0F; wvalid = 1'b1;
      rready = 1'b1;
      tick();
      araddr = 22'h00_0018; arvalid = 1'b1;
      tick();
      chk("rw_same_cycle", 64'(both_cnt - s0), 64'd1);
      wait_r(rc0 + 1);
      chk("rw_pre_value", last_rdata, 64'h11);
      wait_b(b0 + 1);
      do_read(22'h00_0018);
      chk("rw_post_value", last_rdata, 64'h99);

      // Reset with R held and a lone W buffered
      araddr = 22'h00_0008; arvalid = 1'b1; rready = 1'b0;
      tick();
      wdata = 64'hAB; wstrb = 8'h0F; wvalid = 1'b1;
      tick();
      #1;
      chk("mid_rvalid_pre", 64'(rvalid), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rvalid_clr", 64'(rvalid), 64'd0);
      chk("mid_ready_clr", 64'({awready, wready, arready}), 64'd0);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      w0 = wen_cnt; b0 = b_cnt; rc0 = r_cnt;
      rready = 1'b1; bready = 1'b1;
      tick(); tick();
      awaddr = 22'h00_0020; awvalid = 1'b1;
      repeat (5) tick();
      #1;
      chk("post_rst_no_wen", 64'(wen_cnt - w0), 64'd0);
      chk("post_rst_no_b", 64'(b_cnt - b0), 64'd0);
      chk("post_rst_no_r", 64'(r_cnt - rc0), 64'd0);
      chk("post_rst_valids", 64'({bvalid, rvalid}), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/plic_axil_bridge.md
Name: plic_axil_bridge

Overview:
Parametrised AXI4-Lite slave front-end for the PLIC core, the next generation of the PLIC top-level bus wrapper. It generalises bus width (32/64) and lane steering, and accepts AW and W independently through one-entry buffers. It adds address-range decode with optional error response and guarantees that every register access, including side-effecting claim reads, reaches the core exactly once. The PLIC core hangs off its simple register port.

Parameters:
C_S_AXI_DATA_WIDTH, 64, AXI data width; legal values 32 or 64.
C_S_AXI_ADDR_WIDTH, 22, AXI address width.
REG_ADDR_LIMIT, 22'h20_1000, first byte address outside the PLIC register map.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_W/3/1/1  write address channel; AWPROT ignored
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_W/3/1/1  read address channel; ARPROT ignored
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_W/2/1/1  read data channel
reg_waddr  out  ADDR_W  word-aligned core write address, bits[1:0]=0
reg_wdata  out  32  lane-selected write data
reg_wstrb  out  4  lane-selected byte strobes
reg_wen  out  1  one-cycle write pulse
reg_raddr  out  ADDR_W  word-aligned core read address
reg_ren  out  1  one-cycle read pulse; the core applies claim side effects on it
reg_rdata  in  32  core read data, combinational from reg_raddr

Behaviour:
- Reset: all READY, BVALID, RVALID, reg_wen and reg_ren are 0; BRESP, RRESP and RDATA are 0; buffers are empty. READY outputs rise in the first cycle after reset release.
- Lane index is addr[2] when DATA_W=64 and is always 0 when DATA_W=32.
- Write data is taken from lane[idx]. Read data is placed on lane[idx]; other lanes are 0.
- AW buffer and W buffer are 1 entry each. AWREADY = !aw_full; WREADY = !w_full. Each channel is accepted independently, in either order or in the same cycle.
- Commit occurs in the cycle where aw_full && w_full && !BVALID.
  - In range: reg_wen=1 for that cycle.
  - Both buffers clear on commit, and BVALID rises at the next edge.
  - BVALID holds until BREADY. At most one B response is outstanding; the buffers may refill meanwhile.
- Read accept: ARREADY = !RVALID && ready_enabled.
  - On an AR handshake with an in-range address, reg_ren=1 and reg_raddr=ARADDR aligned, combinationally in that cycle. reg_rdata is registered at the edge.
  - RVALID rises next cycle (latency 1) and holds with stable RDATA/RRESP until RREADY.
  - ARREADY returns high in the cycle after RREADY.
- reg_ren fires exactly once per AR handshake; it never re-fires while the RVALID stall is held.
- A simultaneous read and write to the same register in one cycle: the read returns the pre-write value.
- WSTRB lane all-zero: reg_wen still pulses with reg_wstrb=0; response is OKAY.
- Reset asserted mid-transaction: all state clears immediately and the pending transaction is dropped without a response.

Optional Feature:
PLIC_AXIL_SLVERR_EN.
- Defined: an address >= REG_ADDR_LIMIT returns BRESP/RRESP=2'b10 (SLVERR), with no reg_wen/reg_ren and RDATA=0.
- Undefined: the same accesses return OKAY; writes are dropped and reads return 0.
- In both modes, out-of-range accesses never strobe the core.

Decomposition:
- Package plic_axil_pkg holds:
  - the RESP_OKAY/RESP_SLVERR constants;
  - a lane-index function of DATA_W;
  - a typedef for the 32-bit register word;
  - default REG_ADDR_LIMIT.
- Sub-module plic_axil_buf: 1-entry valid/ready holding register, instantiated for AW and for W.

Test Plan:
1. Release reset, idle two cycles -> AWREADY=WREADY=ARREADY=1 from the first post-reset cycle; BVALID=RVALID=0.
2. W (WDATA=64'h0000_0007_0000_0000, WSTRB=8'hF0) arrives 3 cycles before AW (AWADDR=22'h00_0004) -> single reg_wen with waddr=4, wdata=7, wstrb=4'hF; then BVALID with BRESP=0.
3. AR 22'h20_0004 (claim) with reg_rdata=32'd5 and RREADY low for 4 cycles -> reg_ren exactly once; RDATA=64'h0000_0005_0000_0000 held stable; ARREADY low until the cycle after RREADY.
4. Back-to-back writes with BREADY low for 5 cycles -> second AW/W buffered but not committed; second reg_wen occurs only after the first B handshake.
5. Access to 22'h30_0000 -> SLVERR with the macro defined, OKAY/RDATA=0 without it; no reg_wen/reg_ren in either mode.
6. Assert reset while RVALID=1 and a W is buffered -> RVALID=0 immediately; after release no stale B or R response appears and no reg_wen fires.
